// File: rtl/clock_mode_ctrl.sv
// Button synchroniser/debouncer and mode FSM for the clock/stopwatch.
// Optional hold-to-repeat for up/down in the set modes: define AUTO_REPEAT_EN.
module clock_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_action,
    output logic [1:0] mode,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       sw_run,
    output logic       sw_zero_pulse
);

`ifdef AUTO_REPEAT_EN
    localparam bit AR_EN = 1'b1;
`else
    localparam bit AR_EN = 1'b0;
`endif

    // One counter width fits every interval this build actually counts.
    localparam int CMAX =
        !AR_EN ? DEBOUNCE_CYCLES :
        (REPEAT_DELAY >= REPEAT_RATE && REPEAT_DELAY >= DEBOUNCE_CYCLES) ?
            REPEAT_DELAY :
        (REPEAT_RATE >= DEBOUNCE_CYCLES) ? REPEAT_RATE : DEBOUNCE_CYCLES;
    localparam int CW = (CMAX > 2) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        SET_HOUR   = 2'b01,
        SET_MINUTE = 2'b10,
        STOPWATCH  = 2'b11
    } mode_t;

    mode_t state;

    // Button bit order: 0 mode, 1 up, 2 down, 3 action.
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [3:0]    deb_prev;
    logic [3:0]    press;
    logic [CW-1:0] cnt [4];

    logic p_mode;
    logic p_up;
    logic p_down;
    logic p_action;

    assign raw      = {btn_action, btn_down, btn_up, btn_mode};
    assign press    = deb & ~deb_prev;
    assign p_mode   = press[0];
    assign p_up     = press[1];
    assign p_down   = press[2];
    assign p_action = press[3];
    assign mode     = state;

`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

    logic [CW-1:0] rep_cnt;
    logic          rep_armed;
    logic          rep_dn;
    logic          rep_first;
    logic          hold_ok;
    logic          rep_hit;

    // The repeating button must still be the only one of up/down held.
    assign hold_ok = rep_dn ? (deb[2] & ~deb[1]) : (deb[1] & ~deb[2]);
    assign rep_hit = rep_first ? (rep_cnt == RD_LAST) : (rep_cnt == RR_LAST);
`endif

    // Two-flop synchronise each button, then accept a level once it has
    // disagreed with the debounced value for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Mode FSM with registered strobes; a mode press swallows other presses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= RUN;
            inc_pulse     <= 1'b0;
            dec_pulse     <= 1'b0;
            sw_run        <= 1'b0;
            sw_zero_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_dn    <= 1'b0;
            rep_first <= 1'b0;
`endif
        end else begin
            inc_pulse     <= 1'b0;
            dec_pulse     <= 1'b0;
            sw_zero_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
            if (p_mode) begin
                // Encoding order is the mode cycle, so +1 wraps correctly.
                state <= mode_t'(state + 2'd1);
                if (state == STOPWATCH) sw_run <= 1'b0;
            end else begin
                unique case (state)
                    SET_HOUR, SET_MINUTE: begin
                        if (p_up && !p_down) begin
                            inc_pulse <= 1'b1;
`ifdef AUTO_REPEAT_EN
                            rep_armed <= 1'b1;
                            rep_dn    <= 1'b0;
                            rep_first <= 1'b1;
`endif
                        end else if (p_down && !p_up) begin
                            dec_pulse <= 1'b1;
`ifdef AUTO_REPEAT_EN
                            rep_armed <= 1'b1;
                            rep_dn    <= 1'b1;
                            rep_first <= 1'b1;
`endif
                        end
`ifdef AUTO_REPEAT_EN
                        else if (rep_armed && hold_ok) begin
                            rep_armed <= 1'b1;
                            if (rep_hit) begin
                                rep_first <= 1'b0;
                                inc_pulse <= ~rep_dn;
                                dec_pulse <= rep_dn;
                            end else begin
                                rep_cnt <= rep_cnt + CW'(1);
                            end
                        end
`endif
                    end
                    STOPWATCH: begin
                        if (p_action) sw_run <= ~sw_run;
                        if (p_down && !sw_run) sw_zero_pulse <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios, then random buttons.
// A window-based debounce model predicts every output every cycle.
module tb_clock_mode_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int HL = DB + 2;

`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    localparam logic [3:0] BM = 4'b0001;
    localparam logic [3:0] BU = 4'b0010;
    localparam logic [3:0] BD = 4'b0100;
    localparam logic [3:0] BA = 4'b1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_action = 1'b0;
    logic [1:0] mode;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       sw_run;
    logic       sw_zero_pulse;

    always #5 clk = ~clk;

    clock_mode_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_mode     (btn_mode),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_action   (btn_action),
        .mode         (mode),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .sw_run       (sw_run),
        .sw_zero_pulse(sw_zero_pulse)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_inc = 0;
    int n_dec = 0;
    int n_zero = 0;

    logic [HL-1:0] hist [4];
    logic [3:0]    m_deb;
    logic [3:0]    m_debp;
    logic [1:0]    m_mode;
    logic          m_inc;
    logic          m_dec;
    logic          m_run;
    logic          m_zero;
    logic          armed;
    logic          a_dn;
    int            anchor;

    function automatic logic [63:0] outs();
        return 64'({mode, inc_pulse, dec_pulse, sw_run, sw_zero_pulse});
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @%0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [3:0]    r;
        logic [3:0]    ev;
        logic [DB-1:0] win;
        logic          held;
        int            d;
        r = {btn_action, btn_down, btn_up, btn_mode};
        if (!reset_n) begin
            for (int b = 0; b < 4; b++) hist[b] = '0;
            m_deb  = '0;
            m_debp = '0;
            m_mode = 2'd0;
            m_inc  = 1'b0;
            m_dec  = 1'b0;
            m_run  = 1'b0;
            m_zero = 1'b0;
            armed  = 1'b0;
            a_dn   = 1'b0;
            anchor = 0;
            return;
        end
        for (int b = 0; b < 4; b++) hist[b] = {hist[b][HL-2:0], r[b]};
        ev = m_deb & ~m_debp;
        m_inc  = 1'b0;
        m_dec  = 1'b0;
        m_zero = 1'b0;
        if (ev[0]) begin
            if (m_mode == 2'd3) m_run = 1'b0;
            m_mode = m_mode + 2'd1;
            armed = 1'b0;
        end else if (m_mode == 2'd1 || m_mode == 2'd2) begin
            held = a_dn ? (m_deb[2] && !m_deb[1]) : (m_deb[1] && !m_deb[2]);
            if (ev[1] && !ev[2]) begin
                m_inc = 1'b1; armed = 1'b1; a_dn = 1'b0; anchor = cyc;
            end else if (ev[2] && !ev[1]) begin
                m_dec = 1'b1; armed = 1'b1; a_dn = 1'b1; anchor = cyc;
            end else if (AR && armed && held) begin
                d = cyc - anchor;
                if (d == RD || (d > RD && (d - RD) % RR == 0)) begin
                    m_inc = !a_dn;
                    m_dec = a_dn;
                end
            end else begin
                armed = 1'b0;
            end
        end else begin
            armed = 1'b0;
            if (m_mode == 2'd3) begin
                if (ev[2] && !m_run) m_zero = 1'b1;
                if (ev[3]) m_run = !m_run;
            end
        end
        // Synced value lags raw by two edges; flip after DB stable samples.
        m_debp = m_deb;
        for (int b = 0; b < 4; b++) begin
            win = hist[b][DB+1:2];
            if (win == {DB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        if (inc_pulse) n_inc++;
        if (dec_pulse) n_dec++;
        if (sw_zero_pulse) n_zero++;
        chk("cycle", outs(),
            64'({m_mode, m_inc, m_dec, m_run, m_zero}));
    endtask

    task automatic hold(logic [3:0] b, int on, int off);
        {btn_action, btn_down, btn_up, btn_mode} = b;
        repeat (on) tick();
        {btn_action, btn_down, btn_up, btn_mode} = 4'b0000;
        repeat (off) tick();
    endtask

    initial begin
        int i0;
        int d0;
        int z0;
        logic [63:0] mask;
        logic [63:0] emask;
        logic [3:0]  v;

        repeat (3) tick();
        chk("reset", outs(), 64'd0);
        reset_n = 1'b1;

        // 1: mode cycles and wraps, no strobes
        for (int i = 0; i < 4; i++) begin
            hold(BM, 10, 10);
            chk("t1_mode", 64'(mode), 64'((i + 1) % 4));
        end
        chk("t1_quiet", 64'(n_inc + n_dec + n_zero), 64'd0);

        // 2: latency of an up press, glitch rejection
        hold(BM, 10, 10);
        chk("t2_mode", 64'(mode), 64'd1);
        i0 = n_inc;
        btn_up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t2_latency", 64'(inc_pulse), 64'(k == 7));
        end
        btn_up = 1'b0;
        repeat (12) tick();
        chk("t2_single", 64'(n_inc - i0), 64'd1);
        i0 = n_inc;
        btn_up = 1'b1;
        repeat (2) tick();
        btn_up = 1'b0;
        repeat (12) tick();
        chk("t2_glitch", 64'(n_inc - i0), 64'd0);

        // 3: stopwatch start/stop and zero
        hold(BM, 10, 10);
        hold(BM, 10, 10);
        chk("t3_mode", 64'(mode), 64'd3);
        hold(BA, 10, 10);
        chk("t3_run_on", 64'(sw_run), 64'd1);
        z0 = n_zero;
        hold(BD, 10, 10);
        chk("t3_zero_blocked", 64'(n_zero - z0), 64'd0);
        hold(BA, 10, 10);
        chk("t3_run_off", 64'(sw_run), 64'd0);
        hold(BD, 10, 10);
        chk("t3_zero", 64'(n_zero - z0), 64'd1);

        // 4: leaving stopwatch stops it on the same edge
        hold(BA, 10, 10);
        chk("t4_run", 64'(sw_run), 64'd1);
        btn_mode = 1'b1;
        repeat (6) tick();
        chk("t4_before", 64'({mode, sw_run}), 64'b111);
        tick();
        chk("t4_edge", 64'({mode, sw_run}), 64'b000);
        repeat (3) tick();
        btn_mode = 1'b0;
        repeat (12) tick();

        // 5: coincident presses
        hold(BM, 10, 10);
        hold(BM, 10, 10);
        chk("t5_mode", 64'(mode), 64'd2);
        i0 = n_inc;
        d0 = n_dec;
        hold(BU | BD, 10, 10);
        chk("t5_updown", 64'({n_inc - i0, n_dec - d0}), 64'd0);
        hold(BM | BU, 10, 10);
        chk("t5_mode_up", 64'(mode), 64'd3);
        chk("t5_no_inc", 64'(n_inc - i0), 64'd0);
        hold(BM, 10, 10);
        chk("t5_run", 64'(mode), 64'd0);

        // 6: long hold in SET_HOUR, then reset mid-hold
        hold(BM, 10, 10);
        chk("t6_mode", 64'(mode), 64'd1);
        btn_up = 1'b1;
        mask = '0;
        for (int k = 1; k <= 46; k++) begin
            tick();
            if (inc_pulse && k >= 7) mask[k-7] = 1'b1;
        end
        emask = '0;
        for (int o = 0; o < 40; o++)
            if (o == 0 || (AR && (o == RD || (o > RD && (o - RD) % RR == 0))))
                emask[o] = 1'b1;
        chk("t6_repeat", mask, emask);
        btn_mode = 1'b1;
        reset_n = 1'b0;
        repeat (2) tick();
        chk("t6_reset", outs(), 64'd0);
        reset_n = 1'b1;
        i0 = n_inc;
        repeat (6) tick();
        chk("t6_held_pre", 64'(mode), 64'd0);
        tick();
        chk("t6_held_post", 64'(mode), 64'd1);
        repeat (20) tick();
        chk("t6_no_inc", 64'(n_inc - i0), 64'd0);
        btn_mode = 1'b0;
        btn_up = 1'b0;
        repeat (20) tick();

        // random buttons with occasional reset pulses
        for (int c = 0; c < 4000; c++) begin
            v = {btn_action, btn_down, btn_up, btn_mode};
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 19) == 0) v[b] = ~v[b];
            {btn_action, btn_down, btn_up, btn_mode} = v;
            reset_n = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
